// File: rtl/lane_read_scheduler.sv
// Two-lane receive FIFO read sequencer: strict lane 0/1 alternation into
// the merge datapath, with stall timeout, lane-0 resync and status counters.
module lane_read_scheduler #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty_0,
    input  logic             empty_1,
    input  logic [WIDTH-1:0] fifo_data_0,
    input  logic [WIDTH-1:0] fifo_data_1,
    output logic             pop_0,
    output logic             pop_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             lane_out,
    output logic             skew_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LANE0,
        LANE1,
        ERR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cur_empty;
    logic              pop_d;
    logic              pop_lane_d;

    assign pop_0     = (state == LANE0) & enable & ~empty_0;
    assign pop_1     = (state == LANE1) & enable & ~empty_1;
    assign cur_empty = (state == LANE1) ? empty_1 : empty_0;

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            skew_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            skew_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (enable && !empty_0 && !empty_1)
                        state <= LANE0;
                end
                LANE0, LANE1: begin
                    if (!enable) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (!cur_empty) begin
                        state    <= (state == LANE0) ? LANE1 : LANE0;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // skew_err is high for exactly the ERR cycle
                        state    <= ERR;
                        wait_cnt <= '0;
                        skew_err <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // FIFO read data lags its pop by one cycle; capture it one cycle later
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            pop_d      <= 1'b0;
            pop_lane_d <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            lane_out   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            pop_d      <= pop_0 | pop_1;
            pop_lane_d <= pop_1;
            valid_out  <= pop_d;
            if (pop_d) begin
                data_out <= pop_lane_d ? fifo_data_1 : fifo_data_0;
                lane_out <= pop_lane_d;
                if (word_cnt != '1)
                    word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_read_scheduler.sv
// Bench for lane_read_scheduler: two configurations against a queue-based
// model, directed scenarios with literal pins, then randomized traffic.
module tb_lane_read_scheduler;

    localparam int W = 32;

    logic clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    logic         reset;
    logic         enable;
    logic         em   [2][2];
    logic [W-1:0] fd   [2][2];
    logic         pp   [2][2];
    logic         vo   [2];
    logic         lo   [2];
    logic         se   [2];
    logic [W-1:0] dout [2];
    logic [7:0]   wc_a, ec_a;
    logic [1:0]   wc_b, ec_b;

    lane_read_scheduler #(.WIDTH(W), .MAX_WAIT(4), .CNT_W(8)) dut_a (
        .clk_2f(clk_2f), .reset(reset), .enable(enable),
        .empty_0(em[0][0]), .empty_1(em[0][1]),
        .fifo_data_0(fd[0][0]), .fifo_data_1(fd[0][1]),
        .pop_0(pp[0][0]), .pop_1(pp[0][1]),
        .data_out(dout[0]), .valid_out(vo[0]), .lane_out(lo[0]),
        .skew_err(se[0]), .word_cnt(wc_a), .err_cnt(ec_a)
    );

    lane_read_scheduler #(.WIDTH(W), .MAX_WAIT(1), .CNT_W(2)) dut_b (
        .clk_2f(clk_2f), .reset(reset), .enable(enable),
        .empty_0(em[1][0]), .empty_1(em[1][1]),
        .fifo_data_0(fd[1][0]), .fifo_data_1(fd[1][1]),
        .pop_0(pp[1][0]), .pop_1(pp[1][1]),
        .data_out(dout[1]), .valid_out(vo[1]), .lane_out(lo[1]),
        .skew_err(se[1]), .word_cnt(wc_b), .err_cnt(ec_b)
    );

    logic [W-1:0] fq [4][$];
    int           wseq     [2][2];
    bit           push_req [2][2];
    bit           pend     [2][2];
    bit           en_next;

    // model: mode 0 = idle, 1 = streaming, 2 = stall error cycle
    int           mode   [2];
    int           lane   [2];
    int           streak [2];
    bit           p1_v   [2];
    bit           p1_l   [2];
    logic [W-1:0] p1_d   [2];
    bit           m_v    [2];
    bit           m_l    [2];
    logic [W-1:0] m_d    [2];
    int           words  [2];
    int           errs   [2];

    int           tests, fails, cyc;
    logic [W-1:0] log_d [$];
    bit           log_l [$];
    int           log_c [$];
    int           skew_seen, skew_cyc, en_cyc, rc;

    function automatic int mw(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int cap(int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic chk(string nm, int k, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cyc %0d: got %h want %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; lane[k] = 0; streak[k] = 0;
            p1_v[k] = 0; p1_l[k] = 0; p1_d[k] = '0;
            m_v[k] = 0; m_l[k] = 0; m_d[k] = '0;
            words[k] = 0; errs[k] = 0;
            pend[k][0] = 0; pend[k][1] = 0;
        end
    endtask

    task automatic log_clear();
        log_d.delete(); log_l.delete(); log_c.delete();
        skew_seen = 0; skew_cyc = -1;
    endtask

    task automatic apply_edge();
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 2; l++) begin
                if (pend[k][l]) begin
                    fd[k][l] = fq[k*2+l].pop_front();
                    pend[k][l] = 1'b0;
                end
                if (push_req[k][l]) begin
                    fq[k*2+l].push_back({(l == 1) ? 16'hB000 : 16'hA000,
                                         16'(wseq[k][l])});
                    wseq[k][l]++;
                    push_req[k][l] = 1'b0;
                end
                em[k][l] = (fq[k*2+l].size() == 0);
            end
        end
        enable = en_next;
    endtask

    task automatic check_adv();
        for (int k = 0; k < 2; k++) begin
            bit mp0, mp1;
            int wact, eact;
            mp0 = (mode[k] == 1) && (lane[k] == 0) && enable && !em[k][0];
            mp1 = (mode[k] == 1) && (lane[k] == 1) && enable && !em[k][1];
            wact = (k == 0) ? int'(wc_a) : int'(wc_b);
            eact = (k == 0) ? int'(ec_a) : int'(ec_b);
            chk("pop_0", k, 32'(pp[k][0]), 32'(mp0));
            chk("pop_1", k, 32'(pp[k][1]), 32'(mp1));
            chk("valid_out", k, 32'(vo[k]), 32'(m_v[k]));
            chk("lane_out", k, 32'(lo[k]), 32'(m_l[k]));
            chk("data_out", k, dout[k], m_d[k]);
            chk("skew_err", k, 32'(se[k]), 32'(mode[k] == 2));
            if (!m_v[k]) chk("word_cnt", k, wact, words[k]);
            if (mode[k] != 2) chk("err_cnt", k, eact, errs[k]);
            if (k == 0 && vo[0]) begin
                log_d.push_back(dout[0]);
                log_l.push_back(lo[0]);
                log_c.push_back(cyc);
            end
            if (k == 0 && se[0]) begin
                skew_seen++;
                skew_cyc = cyc;
            end
            m_v[k] = p1_v[k];
            if (p1_v[k]) begin
                m_d[k] = p1_d[k];
                m_l[k] = p1_l[k];
                if (words[k] < cap(k)) words[k]++;
            end
            p1_v[k] = mp0 | mp1;
            p1_l[k] = mp1;
            if (mp0) p1_d[k] = fq[k*2][0];
            if (mp1) p1_d[k] = fq[k*2+1][0];
            pend[k][0] = mp0;
            pend[k][1] = mp1;
            case (mode[k])
                0: if (enable && !em[k][0] && !em[k][1]) begin
                    mode[k] = 1; lane[k] = 0; streak[k] = 0;
                end
                1: if (!enable) begin
                    mode[k] = 0; streak[k] = 0;
                end else if (mp0 || mp1) begin
                    lane[k] = 1 - lane[k]; streak[k] = 0;
                end else if (streak[k] == mw(k) - 1) begin
                    mode[k] = 2; streak[k] = 0;
                    if (errs[k] < cap(k)) errs[k]++;
                end else begin
                    streak[k]++;
                end
                default: mode[k] = 0;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk_2f);
        #1;
        apply_edge();
        @(negedge clk_2f);
        check_adv();
        cyc++;
    endtask

    task automatic push_step(bit l0, bit l1);
        for (int k = 0; k < 2; k++) begin
            push_req[k][0] = l0;
            push_req[k][1] = l1;
        end
        step();
    endtask

    task automatic do_reset();
        @(posedge clk_2f);
        #1;
        apply_edge();
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pop_0", k, 32'(pp[k][0]), 0);
            chk("rst_pop_1", k, 32'(pp[k][1]), 0);
            chk("rst_valid", k, 32'(vo[k]), 0);
            chk("rst_lane", k, 32'(lo[k]), 0);
            chk("rst_data", k, dout[k], 0);
            chk("rst_skew", k, 32'(se[k]), 0);
        end
        chk("rst_wc", 0, 32'(wc_a), 0);
        chk("rst_ec", 0, 32'(ec_a), 0);
        chk("rst_wc", 1, 32'(wc_b), 0);
        chk("rst_ec", 1, 32'(ec_b), 0);
        model_reset();
        @(negedge clk_2f);
        reset = 1'b1;
        #1;
        rc = cyc;
        check_adv();
        cyc++;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b1; enable = 1'b0; en_next = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 2; l++) begin
                em[k][l] = 1'b1; fd[k][l] = '0;
                wseq[k][l] = 0; push_req[k][l] = 1'b0;
            end
        end
        model_reset();
        log_clear();
        do_reset();

        // preloaded 4+4 words stream in strict alternation
        log_clear();
        repeat (4) push_step(1, 1);
        en_next = 1; en_cyc = cyc;
        repeat (9) step();
        en_next = 0;
        repeat (4) step();
        chk("s1_count", 0, log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            logic [W-1:0] ex;
            ex = {(i % 2 == 1) ? 16'hB000 : 16'hA000, 16'(i / 2)};
            chk("s1_word", i, log_d[i], ex);
            chk("s1_lane", i, 32'(log_l[i]), i % 2);
        end
        if (log_c.size() > 0) chk("s1_latency", 0, log_c[0] - en_cyc, 3);
        chk("s1_wc", 0, 32'(wc_a), 8);
        chk("s1_wc_sat", 1, 32'(wc_b), 3);
        chk("s1_ec", 0, 32'(ec_a), 0);

        // lane 1 stalls two cycles: tolerated, two-cycle valid gap
        log_clear();
        push_step(1, 1);
        push_step(1, 0);
        en_next = 1;
        repeat (6) step();
        push_step(0, 1);
        en_next = 0;
        repeat (4) step();
        chk("s2_count", 0, log_d.size(), 4);
        if (log_c.size() >= 4) chk("s2_gap", 0, log_c[3] - log_c[2], 3);
        chk("s2_ec", 0, 32'(ec_a), 0);
        chk("s2_skew_n", 0, skew_seen, 0);

        // lane 1 stalls four cycles: timeout, idle, lane-0 restart
        log_clear();
        push_step(1, 1);
        push_step(1, 0);
        en_next = 1; en_cyc = cyc;
        repeat (11) step();
        push_step(0, 1);
        step();
        push_step(1, 0);
        step();
        step();
        en_next = 0;
        repeat (4) step();
        chk("s3_ec", 0, 32'(ec_a), 1);
        chk("s3_skew_n", 0, skew_seen, 1);
        chk("s3_skew_at", 0, skew_cyc - en_cyc, 8);
        chk("s3_count", 0, log_d.size(), 5);
        if (log_l.size() >= 5) begin
            chk("s3_rs_lane", 0, 32'(log_l[3]), 0);
            chk("s3_rs_lane", 1, 32'(log_l[4]), 1);
        end

        // enable drops right after a lane-0 pop
        log_clear();
        push_step(1, 1);
        en_next = 1; en_cyc = cyc;
        step();
        step();
        en_next = 0;
        repeat (4) step();
        chk("s4_count", 0, log_d.size(), 1);
        if (log_c.size() > 0) chk("s4_at", 0, log_c[0] - en_cyc, 3);
        en_next = 1;
        step();
        push_step(1, 0);
        step();
        step();
        en_next = 0;
        repeat (4) step();
        chk("s4_count2", 0, log_d.size(), 3);
        if (log_l.size() >= 3) begin
            chk("s4_rs_lane", 0, 32'(log_l[1]), 0);
            chk("s4_rs_lane", 1, 32'(log_l[2]), 1);
        end

        // reset with pops in flight
        repeat (3) push_step(1, 1);
        en_next = 1;
        repeat (4) step();
        do_reset();
        log_clear();
        repeat (8) step();
        en_next = 0;
        repeat (4) step();
        if (log_c.size() > 0) begin
            chk("s5_restart", 0, log_c[0] - rc, 3);
            chk("s5_lane", 0, 32'(log_l[0]), 0);
        end else begin
            chk("s5_restart", 0, 0, 3);
        end

        // randomized traffic with varying fill rates
        for (int blk = 0; blk < 8; blk++) begin
            int rate;
            rate = 25 + blk * 9;
            for (int n = 0; n < 500; n++) begin
                en_next = ($urandom_range(0, 15) != 0);
                for (int k = 0; k < 2; k++) begin
                    for (int l = 0; l < 2; l++) begin
                        push_req[k][l] = (fq[k*2+l].size() < 12) &&
                                         ($urandom_range(0, 99) < rate);
                    end
                end
                if ($urandom_range(0, 1499) == 0) do_reset();
                else step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_read_scheduler.md
Name: lane_read_scheduler

Overview:
- Sequences reads from the two per-lane receive FIFOs into the lane-merge datapath at clk_2f.
- Enforces strict lane_0/lane_1 alternation so the merged stream keeps word order.
- Aligns start-up on lane 0, tolerates bounded inter-lane skew, and resynchronises on a lane stall.
- Outputs one merged word stream with valid, plus error and word-count status.

Parameters:
WIDTH, 32, data word width per lane
MAX_WAIT, 4, consecutive empty cycles tolerated on the expected lane before error (legal range >=1)
CNT_W, 8, width of the word and error status counters

Ports:
clk_2f  input  1  block clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  scheduler run enable
empty_0  input  1  lane 0 FIFO empty
empty_1  input  1  lane 1 FIFO empty
fifo_data_0  input  WIDTH  lane 0 FIFO read data, valid the cycle after pop_0
fifo_data_1  input  WIDTH  lane 1 FIFO read data, valid the cycle after pop_1
pop_0  output  1  lane 0 FIFO read strobe (combinational from state)
pop_1  output  1  lane 1 FIFO read strobe (combinational from state)
data_out  output  WIDTH  merged data word, registered
valid_out  output  1  data_out valid, registered
lane_out  output  1  lane that sourced data_out
skew_err  output  1  one-cycle pulse on lane-stall timeout
word_cnt  output  CNT_W  saturating count of words output
err_cnt  output  CNT_W  saturating count of skew_err events

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, wait_cnt=0.
  - All outputs 0, including data_out, word_cnt and err_cnt.
  - Internal pop pipeline flags cleared.
- States: IDLE, LANE0, LANE1, ERR (registered).
- pop_0 = (state==LANE0) & enable & !empty_0.
- pop_1 = (state==LANE1) & enable & !empty_1.
- At most one pop per cycle, never both.
- IDLE:
  - No pops.
  - enable=1 & !empty_0 & !empty_1 -> LANE0 next cycle.
  - Otherwise stay in IDLE.
- LANE0:
  - enable=0 -> IDLE, no pop, wait_cnt=0.
  - pop_0=1 -> LANE1, wait_cnt=0.
  - empty_0=1 -> wait_cnt+1. When wait_cnt==MAX_WAIT-1 that cycle -> ERR.
- LANE1: same as LANE0 with lane 1 signals; a pop goes to LANE0.
- ERR (one cycle):
  - skew_err=1 (registered, asserted during the ERR cycle).
  - err_cnt+1, saturating at all-ones.
  - wait_cnt=0, next state IDLE.
  - No pops. Pending output pipeline still drains.
- Output pipeline, latency 2:
  - Pop asserted in cycle N; the FIFO presents data in cycle N+1.
  - Block captures it at the end of N+1, so data_out/valid_out/lane_out are visible in cycle N+2.
  - Back-to-back pops give continuous valid_out=1.
  - Cycles without a pop two cycles earlier give valid_out=0. data_out then holds its last value; lane_out holds.
- word_cnt increments on each valid_out=1 cycle, saturating at 2^CNT_W-1. Cleared only by reset.
- Simultaneous enable drop while a pop is in flight: the in-flight word still completes on valid_out.
- Reset mid-operation: everything clears immediately. In-flight words are discarded, and the restart realigns on lane 0 through IDLE.
- Resync always restarts on lane 0. The scheduler never begins or resumes on lane 1 from IDLE.
- MAX_WAIT=1: any single empty cycle on the expected lane goes straight to ERR.

Test Plan:
- Both FIFOs preloaded with 4 words (L0: A0..A3, L1: B0..B3), enable=1 -> pops alternate 0,1,0,1..., output A0,B0,A1,B1,...,A3,B3 on 8 consecutive valid cycles; lane_out 0,1,0,1...; first valid 3 cycles after enable rises (1 cycle IDLE→LANE0, +2 latency); word_cnt=8.
- Lane 1 empty for 2 cycles after B0 (MAX_WAIT=4) -> no error; LANE1 holds with no pops; stream resumes A0,B0,A1,B1 with a 2-cycle valid gap; err_cnt=0.
- Lane 1 empty for 4 cycles -> skew_err pulses once on the 5th cycle; err_cnt=1; state returns to IDLE; restarts on lane 0 only when both lanes are non-empty.
- enable deasserted the cycle after pop_0 -> no further pops; the popped word still appears on valid_out 2 cycles later; re-enable restarts at lane 0.
- Assert reset mid-stream with pops in flight -> all outputs 0 asynchronously, no valid_out after release until a new IDLE→LANE0 sequence; counters 0.
- CNT_W=2 with 6 words streamed -> word_cnt saturates at 3.
